// File: rtl/stuck_at_scan_engine.sv
// Stuck-at fault-grading engine for the cone Z = (&grpA) ^ ~(|grpB).
// Walks every 2W-bit input pattern, compares good and faulty Z, and reports detection stats.
module stuck_at_scan_engine #(
  parameter int unsigned W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      fault_site,
  input  logic            stuck_val,
  input  logic            stop_first,
  output logic            busy,
  output logic            done,
  output logic            detected,
  output logic [2*W-1:0]  first_pat,
  output logic [2*W:0]    det_count,
  output logic            z_good,
  output logic            z_faulty
);

  localparam int unsigned PW = 2 * W;

  localparam logic [1:0] SiteE = 2'd0;
  localparam logic [1:0] SiteF = 2'd1;
  localparam logic [1:0] SiteG = 2'd2;
  localparam logic [1:0] SiteZ = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pattern_q, pattern_d;
  logic [1:0]      site_q, site_d;
  logic            sa_q, sa_d;
  logic            stop_q, stop_d;
  logic            detected_q, detected_d;
  logic [PW-1:0]   first_q, first_d;
  logic [PW:0]     count_q, count_d;
  logic            zg_q, zg_d;
  logic            zf_q, zf_d;

  logic [W-1:0] grp_a, grp_b;
  logic         e_good, f_good, g_good, z_good_c;
  logic         e_flt, f_flt, g_flt, z_flt_c;
  logic         mismatch;
  logic         last_pat;

  assign grp_a = pattern_q[PW-1:W];
  assign grp_b = pattern_q[W-1:0];

  assign e_good   = &grp_a;
  assign f_good   = |grp_b;
  assign g_good   = ~f_good;
  assign z_good_c = e_good ^ g_good;

  // Each faulty net feeds the next, so a forced upstream net propagates downstream.
  assign e_flt   = (site_q == SiteE) ? sa_q : e_good;
  assign f_flt   = (site_q == SiteF) ? sa_q : f_good;
  assign g_flt   = (site_q == SiteG) ? sa_q : ~f_flt;
  assign z_flt_c = (site_q == SiteZ) ? sa_q : (e_flt ^ g_flt);

  assign mismatch = z_good_c ^ z_flt_c;
  assign last_pat = (pattern_q == {PW{1'b1}});

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    site_d     = site_q;
    sa_d       = sa_q;
    stop_d     = stop_q;
    detected_d = detected_q;
    first_d    = first_q;
    count_d    = count_q;
    zg_d       = zg_q;
    zf_d       = zf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          site_d     = fault_site;
          sa_d       = stuck_val;
          stop_d     = stop_first;
          detected_d = 1'b0;
          first_d    = '0;
          count_d    = '0;
          zg_d       = 1'b0;
          zf_d       = 1'b0;
          pattern_d  = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        zg_d = z_good_c;
        zf_d = z_flt_c;
        if (mismatch) begin
          count_d = count_q + 1'b1;
          if (!detected_q) begin
            detected_d = 1'b1;
            first_d    = pattern_q;
          end
        end
        // Counter holds at the last pattern instead of wrapping.
        if (last_pat || (stop_q && mismatch)) begin
          state_d = StDone;
        end else begin
          pattern_d = pattern_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pattern_q  <= '0;
      site_q     <= 2'd0;
      sa_q       <= 1'b0;
      stop_q     <= 1'b0;
      detected_q <= 1'b0;
      first_q    <= '0;
      count_q    <= '0;
      zg_q       <= 1'b0;
      zf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      site_q     <= site_d;
      sa_q       <= sa_d;
      stop_q     <= stop_d;
      detected_q <= detected_d;
      first_q    <= first_d;
      count_q    <= count_d;
      zg_q       <= zg_d;
      zf_q       <= zf_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign detected  = detected_q;
  assign first_pat = first_q;
  assign det_count = count_q;
  assign z_good    = zg_q;
  assign z_faulty  = zf_q;

endmodule

// File: tb/tb_stuck_at_scan_engine.sv
// Directed bench for stuck_at_scan_engine at W=2 (16 patterns per scan).
module tb_stuck_at_scan_engine;

  localparam int unsigned W = 2;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [1:0]     fault_site;
  logic           stuck_val;
  logic           stop_first;
  logic           busy;
  logic           done;
  logic           detected;
  logic [2*W-1:0] first_pat;
  logic [2*W:0]   det_count;
  logic           z_good;
  logic           z_faulty;

  int n_cmp;
  int n_bad;

  stuck_at_scan_engine #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fault_site (fault_site),
    .stuck_val  (stuck_val),
    .stop_first (stop_first),
    .busy       (busy),
    .done       (done),
    .detected   (detected),
    .first_pat  (first_pat),
    .det_count  (det_count),
    .z_good     (z_good),
    .z_faulty   (z_faulty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [1:0] site, input logic sa, input logic stp);
    start      = 1'b1;
    fault_site = site;
    stuck_val  = sa;
    stop_first = stp;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      tick();
    end
    if (cyc >= 200) check_eq({tag, "/timeout"}, 1, 0);
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] site, input logic sa,
                               input logic stp, input int exp_cyc, input int exp_first,
                               input int exp_cnt, input int exp_zg, input int exp_zf);
    int cyc;
    start_scan(site, sa, stp);
    wait_done(tag, cyc);
    check_eq({tag, "/busy_cycles"}, cyc, exp_cyc);
    check_eq({tag, "/done"}, 32'(done), 1);
    check_eq({tag, "/detected"}, 32'(detected), 1);
    check_eq({tag, "/first_pat"}, 32'(first_pat), exp_first);
    check_eq({tag, "/det_count"}, 32'(det_count), exp_cnt);
    check_eq({tag, "/z_good"}, 32'(z_good), exp_zg);
    check_eq({tag, "/z_faulty"}, 32'(z_faulty), exp_zf);
    tick();
    check_eq({tag, "/done_pulse_end"}, 32'(done), 0);
    check_eq({tag, "/held_count"}, 32'(det_count), exp_cnt);
  endtask

  initial begin
    int cyc;
    int seen_done;
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    fault_site = 2'd0;
    stuck_val  = 1'b0;
    stop_first = 1'b0;

    #12;
    check_eq("rst/busy", 32'(busy), 0);
    check_eq("rst/done", 32'(done), 0);
    check_eq("rst/detected", 32'(detected), 0);
    check_eq("rst/first_pat", 32'(first_pat), 0);
    check_eq("rst/det_count", 32'(det_count), 0);
    check_eq("rst/z_good", 32'(z_good), 0);
    check_eq("rst/z_faulty", 32'(z_faulty), 0);
    rst_n = 1'b1;
    tick();

    // Last pattern 4'hF: good Z = 1 (e=1, g=0).
    run_and_check("f_sa0",  2'd1, 1'b0, 1'b0, 16, 4'h1, 12, 1, 0);
    run_and_check("e_sa0",  2'd0, 1'b0, 1'b0, 16, 4'hC,  4, 1, 0);
    run_and_check("e_sa1",  2'd0, 1'b1, 1'b0, 16, 4'h0, 12, 1, 1);
    run_and_check("z_sa0",  2'd3, 1'b0, 1'b0, 16, 4'h0,  6, 1, 0);
    run_and_check("z_sa1",  2'd3, 1'b1, 1'b0, 16, 4'h1, 10, 1, 1);
    run_and_check("g_sa1",  2'd2, 1'b1, 1'b0, 16, 4'h1, 12, 1, 0);
    // Stops at pattern 1: good Z = 0, faulty Z = 1.
    run_and_check("f_sa0_stop", 2'd1, 1'b0, 1'b1, 2, 4'h1, 1, 0, 1);

    // start pulsed mid-scan with a different fault must be ignored.
    start_scan(2'd0, 1'b0, 1'b0);
    tick();
    tick();
    start      = 1'b1;
    fault_site = 2'd3;
    stuck_val  = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign", cyc);
    check_eq("ign/busy_cycles", cyc + 3, 16);
    check_eq("ign/det_count", 32'(det_count), 4);
    check_eq("ign/first_pat", 32'(first_pat), 4'hC);
    tick();

    // Asynchronous reset at pattern 5 of an f SA0 scan.
    start_scan(2'd1, 1'b0, 1'b0);
    repeat (5) tick();
    check_eq("abort/pre_detected", 32'(detected), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort/busy", 32'(busy), 0);
    check_eq("abort/done", 32'(done), 0);
    check_eq("abort/detected", 32'(detected), 0);
    check_eq("abort/first_pat", 32'(first_pat), 0);
    check_eq("abort/det_count", 32'(det_count), 0);
    check_eq("abort/z_good", 32'(z_good), 0);
    check_eq("abort/z_faulty", 32'(z_faulty), 0);
    #3 rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) seen_done++;
    end
    check_eq("abort/no_done", seen_done, 0);
    run_and_check("after_abort", 2'd1, 1'b0, 1'b0, 16, 4'h1, 12, 1, 0);

    // Back-to-back: start held high across the done pulse.
    start      = 1'b1;
    fault_site = 2'd1;
    stuck_val  = 1'b0;
    stop_first = 1'b0;
    tick();
    wait_done("b2b1", cyc);
    check_eq("b2b1/busy_cycles", cyc, 16);
    check_eq("b2b1/done", 32'(done), 1);
    check_eq("b2b1/det_count", 32'(det_count), 12);
    fault_site = 2'd0;
    tick();
    check_eq("b2b/idle_busy", 32'(busy), 0);
    check_eq("b2b/idle_count", 32'(det_count), 12);
    tick();
    check_eq("b2b2/busy", 32'(busy), 1);
    check_eq("b2b2/cleared_count", 32'(det_count), 0);
    check_eq("b2b2/cleared_detected", 32'(detected), 0);
    check_eq("b2b2/cleared_first", 32'(first_pat), 0);
    start = 1'b0;
    wait_done("b2b2", cyc);
    check_eq("b2b2/busy_cycles", cyc, 16);
    check_eq("b2b2/det_count", 32'(det_count), 4);
    check_eq("b2b2/first_pat", 32'(first_pat), 4'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
